mux_2_1_reg: RTL and testbench
==============================

Name: mux_2_1_reg

Overview:
- Parameterised 2:1 data selector with a combinational output and a registered output stage.
- `select` chooses between `i0` and `i1`.
- `y` follows the inputs with zero latency; `y_q` and `y_q_vld` give a one-cycle-registered copy for timing-closed consumers.
- Leaf datapath primitive, instantiated wherever a two-source steering point is needed.

Parameters:
- WIDTH, 1, bit width of `i0`, `i1`, `y` and `y_q` (legal range 1..64).
- RST_VAL, 0, value loaded into `y_q` on reset (WIDTH bits, zero-extended).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable for the registered stage.
- select  input  1  0 selects `i0`, 1 selects `i1`.
- i0  input  WIDTH  data input 0.
- i1  input  WIDTH  data input 1.
- y  output  WIDTH  combinational mux output.
- y_q  output  WIDTH  registered mux output.
- y_q_vld  output  1  high when `y_q` holds data captured with `en`=1.
- sel_q  output  1  registered copy of `select` matching `y_q`.

Behaviour:
- Combinational path: `y` = `select` ? `i1` : `i0`, evaluated continuously and independent of `clk`, `rst` and `en`.
- Full WIDTH=1 truth table for `{select,i0,i1}` 000..111 gives `y` = 0,0,1,1,0,1,0,1.
- X/Z on `select` is outside the contract; simulation models drive `y` = X in that case.
- Reset (`rst`=1 at a rising edge):
  - `y_q` <= RST_VAL.
  - `y_q_vld` <= 0.
  - `sel_q` <= 0.
  - Reset has priority over `en`.
  - `y` is unaffected by reset.
- Capture (`rst`=0, `en`=1 at a rising edge): `y_q` <= current `y`, `sel_q` <= `select`, `y_q_vld` <= 1.
- Hold (`rst`=0, `en`=0): `y_q`, `sel_q` and `y_q_vld` keep their values. `y_q_vld` never falls except on reset.
- Latency: `y` has 0 cycles; `y_q` has 1 cycle after the capturing edge.
- Simultaneous `select` and data change in the same cycle: the registered stage captures the post-change `y` (both are sampled at the same edge).
- Reset asserted mid-stream: outputs take reset values at that edge. The first capture after release occurs at the first edge with `rst`=0 and `en`=1.
- No handshake back-pressure; the block always accepts.

Optional Feature:
- Macro: `MUX_2_1_REG_SWITCH_CNT_EN`.
- Defined:
  - Adds output `sw_cnt` [15:0], counting rising edges where `en`=1 and `select` differs from `sel_q`.
  - The first capture after reset is not counted.
  - Saturates at 16'hFFFF (no wrap).
  - Cleared to 0 by `rst`.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package `mux_pkg` holds:
  - constant `MUX_SEL_I0` = 1'b0 and `MUX_SEL_I1` = 1'b1;
  - typedef `sw_cnt_t` = logic [15:0];
  - constant `SW_CNT_MAX`.
- One natural sub-module: `mux_2_1_comb`, the pure combinational selector parameterised by WIDTH, instantiated once for `y`.
- Registered stage and optional counter stay in the top block.

Test Plan:
- WIDTH=1: sweep `{select,i0,i1}` = 0..7, 10 time units each -> `y` = 0,0,1,1,0,1,0,1; `y` changes within the same timestep as its inputs.
- Reset: hold `rst`=1 for 2 edges with `en`=1, `i0`=1 -> `y_q`=RST_VAL, `y_q_vld`=0, `sel_q`=0, while `y`=1 combinationally.
- Capture/latency, WIDTH=8: `i0`=8'hA5, `i1`=8'h3C, `select`=1, `en`=1 -> `y`=8'h3C immediately; `y_q`=8'h3C, `sel_q`=1, `y_q_vld`=1 after the next edge.
- Hold: after the capture above, drop `en` and change `i1`=8'hFF, `select`=0 -> `y`=8'hA5 while `y_q` stays 8'h3C and `sel_q` stays 1 for 5 edges.
- Reset priority: `rst`=1 and `en`=1 on the same edge with `y`=8'hFF -> `y_q`=RST_VAL, `y_q_vld`=0.
- With `MUX_2_1_REG_SWITCH_CNT_EN`: alternate `select` 0,1,0,1 over 4 enabled edges after reset -> `sw_cnt`=3; assert `rst` -> `sw_cnt`=0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the 2:1 selector family: select encodings,
// switch-counter type and its saturation limit.
package mux_pkg;

    localparam logic MUX_SEL_I0 = 1'b0;
    localparam logic MUX_SEL_I1 = 1'b1;

    typedef logic [15:0] sw_cnt_t;

    localparam sw_cnt_t SW_CNT_MAX = 16'hFFFF;

    // Saturating increment: holds at SW_CNT_MAX instead of wrapping.
    function automatic sw_cnt_t sw_cnt_inc(input sw_cnt_t cnt);
        sw_cnt_t nxt;
        if (cnt == SW_CNT_MAX) begin
            nxt = cnt;
        end else begin
            nxt = cnt + 16'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mux_2_1_comb.sv
// Pure combinational 2:1 selector, parameterised by WIDTH.
// An unknown select produces an all-X output in simulation.
module mux_2_1_comb
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             select,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic [WIDTH-1:0] y
);

    // Steer i0 or i1 to y; anything other than a clean 0/1 select gives X.
    always_comb begin
        y = 'x;
        case (select)
            MUX_SEL_I0: y = i0;
            MUX_SEL_I1: y = i1;
            default:    y = 'x;
        endcase
    end

endmodule

// File: rtl/mux_2_1_reg.sv
// 2:1 selector with a zero-latency output y and a one-cycle registered copy
// (y_q, sel_q, y_q_vld). Optional macro MUX_2_1_REG_SWITCH_CNT_EN adds a
// saturating sw_cnt output counting enabled captures whose select differs
// from the previously captured one.
module mux_2_1_reg
    import mux_pkg::*;
#(
    parameter int          WIDTH   = 1,
    parameter logic [63:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             select,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             y_q_vld,
    output logic             sel_q
`ifdef MUX_2_1_REG_SWITCH_CNT_EN
    ,
    output sw_cnt_t          sw_cnt
`endif
);

    localparam logic [WIDTH-1:0] RST_Q = RST_VAL[WIDTH-1:0];

    mux_2_1_comb #(
        .WIDTH (WIDTH)
    ) u_sel (
        .select (select),
        .i0     (i0),
        .i1     (i1),
        .y      (y)
    );

    // Registered stage: reset wins over en; valid only falls on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= RST_Q;
            sel_q   <= MUX_SEL_I0;
            y_q_vld <= 1'b0;
        end else if (en) begin
            y_q     <= y;
            sel_q   <= select;
            y_q_vld <= 1'b1;
        end
    end

`ifdef MUX_2_1_REG_SWITCH_CNT_EN
    // Switch counter: y_q_vld low means no capture since reset, so the
    // first capture is never treated as a switch.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_cnt <= '0;
        end else if (en && y_q_vld && (select != sel_q)) begin
            sw_cnt <= sw_cnt_inc(sw_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_mux_2_1_reg.sv
// Bench for mux_2_1_reg: WIDTH=1 truth-table sweep, directed WIDTH=8
// reset/capture/hold/priority cases, then randomized traffic against a
// behavioural model. Covers sw_cnt when MUX_2_1_REG_SWITCH_CNT_EN is set.
module tb_mux_2_1_reg;

    localparam logic [7:0] RV8 = 8'h5A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=1 instance
    logic       rst1, en1, sel1;
    logic [0:0] a1, b1, y1, yq1;
    logic       vld1, selq1;
    // WIDTH=8 instance
    logic       rst, en, sel;
    logic [7:0] a8, b8, y8, yq8;
    logic       vld8, selq8;
`ifdef MUX_2_1_REG_SWITCH_CNT_EN
    logic [15:0] cnt1, cnt8;
`endif

    mux_2_1_reg #(.WIDTH(1), .RST_VAL(64'd0)) u_w1 (
        .clk(clk), .rst(rst1), .en(en1), .select(sel1), .i0(a1), .i1(b1),
        .y(y1), .y_q(yq1), .y_q_vld(vld1), .sel_q(selq1)
`ifdef MUX_2_1_REG_SWITCH_CNT_EN
        , .sw_cnt(cnt1)
`endif
    );

    mux_2_1_reg #(.WIDTH(8), .RST_VAL(64'(RV8))) u_w8 (
        .clk(clk), .rst(rst), .en(en), .select(sel), .i0(a8), .i1(b8),
        .y(y8), .y_q(yq8), .y_q_vld(vld8), .sel_q(selq8)
`ifdef MUX_2_1_REG_SWITCH_CNT_EN
        , .sw_cnt(cnt8)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model of the WIDTH=8 registered stage
    logic [7:0]  m_yq   = RV8;
    logic        m_vld  = 1'b0;
    logic        m_selq = 1'b0;
    int unsigned m_cnt  = 0;

    function automatic logic [7:0] ref_y(input logic s, input logic [7:0] a, input logic [7:0] b);
        return s ? b : a;
    endfunction

    task automatic check_y(input string tag);
        chk(tag, 64'(y8), 64'(ref_y(sel, a8, b8)));
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".y_q"}, 64'(yq8), 64'(m_yq));
        chk({tag, ".vld"}, 64'(vld8), 64'(m_vld));
        chk({tag, ".sel_q"}, 64'(selq8), 64'(m_selq));
`ifdef MUX_2_1_REG_SWITCH_CNT_EN
        chk({tag, ".sw_cnt"}, 64'(cnt8), 64'(m_cnt));
`endif
    endtask

    // One clock edge: update the model from the inputs present at the edge,
    // then compare 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst) begin
            m_yq = RV8; m_vld = 1'b0; m_selq = 1'b0; m_cnt = 0;
        end else if (en) begin
            if (m_vld && (sel != m_selq) && (m_cnt < 65535)) m_cnt++;
            m_yq = ref_y(sel, a8, b8); m_selq = sel; m_vld = 1'b1;
        end
        #1;
        check_regs(tag);
        check_y({tag, ".y"});
    endtask

    initial begin
        logic [7:0] tt;
        logic [2:0] k;
        tt = 8'b1010_1100;  // bit n = expected y for {select,i0,i1} = n
        rst1 = 1'b1; en1 = 1'b1; sel1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        rst = 1'b1; en = 1'b1; sel = 1'b0; a8 = 8'h01; b8 = 8'h00;

        // WIDTH=1 sweep, 10 time units per pattern; w8 sits in reset meanwhile
        for (int n = 0; n < 8; n++) begin
            k = 3'(n);
            {sel1, a1, b1} = k;
            #1;
            chk($sformatf("w1.tt%0d", n), 64'(y1), 64'(tt[n]));
            #9;
        end

        // Reset held with en=1 and i0=1: y=1, registered stage at reset values
        chk("w8.rst.y", 64'(y8), 64'h1);
        chk("w8.rst.y_q", 64'(yq8), 64'h5A);
        chk("w8.rst.vld", 64'(vld8), 64'h0);
        chk("w8.rst.sel_q", 64'(selq8), 64'h0);
        chk("w1.rst.y_q", 64'(yq1), 64'h0);
        chk("w1.rst.vld", 64'(vld1), 64'h0);

        // WIDTH=1 capture then hold
        rst1 = 1'b0; sel1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
        @(posedge clk); #1;
        chk("w1.cap.y_q", 64'(yq1), 64'h1);
        chk("w1.cap.vld", 64'(vld1), 64'h1);
        chk("w1.cap.sel_q", 64'(selq1), 64'h1);
        en1 = 1'b0; sel1 = 1'b0;
        @(posedge clk); #1;
        chk("w1.hold.y_q", 64'(yq1), 64'h1);
        chk("w1.hold.sel_q", 64'(selq1), 64'h1);

        // Capture / latency at WIDTH=8
        rst = 1'b0; en = 1'b1; a8 = 8'hA5; b8 = 8'h3C; sel = 1'b1;
        #1;
        chk("cap.y_now", 64'(y8), 64'h3C);
        chk("cap.y_q_before", 64'(yq8), 64'h5A);
        tick("cap");
        chk("cap.y_q", 64'(yq8), 64'h3C);
        chk("cap.sel_q", 64'(selq8), 64'h1);
        chk("cap.vld", 64'(vld8), 64'h1);

        // Hold for 5 edges with en=0 while inputs move
        en = 1'b0; b8 = 8'hFF; sel = 1'b0;
        #1;
        chk("hold.y", 64'(y8), 64'hA5);
        for (int n = 0; n < 5; n++) begin
            tick("hold");
            chk($sformatf("hold%0d.y_q", n), 64'(yq8), 64'h3C);
            chk($sformatf("hold%0d.sel_q", n), 64'(selq8), 64'h1);
        end

        // Reset beats en on the same edge
        rst = 1'b1; en = 1'b1; sel = 1'b1;
        #1;
        chk("prio.y", 64'(y8), 64'hFF);
        tick("prio");
        chk("prio.y_q", 64'(yq8), 64'h5A);
        chk("prio.vld", 64'(vld8), 64'h0);

        // Alternating select over 4 enabled edges after reset
        rst = 1'b0; en = 1'b1;
        for (int n = 0; n < 4; n++) begin
            sel = 1'(n & 1);
            tick("alt");
        end
`ifdef MUX_2_1_REG_SWITCH_CNT_EN
        chk("alt.sw_cnt", 64'(cnt8), 64'd3);
        rst = 1'b1;
        tick("alt.rst");
        chk("alt.rst.sw_cnt", 64'(cnt8), 64'd0);
        rst = 1'b0;
`endif

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 19) == 0);
            en  = 1'($urandom_range(0, 1));
            sel = 1'($urandom_range(0, 1));
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            #1;
            check_y("rnd.y_now");
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
